reg_writeback_queue: RTL and testbench

//  Write-side initiator for the register bank write port (C/Cdata/W).

---
 rtl/reg_writeback_queue.sv | 160 ++++++++++++++++
 tb/tb_reg_writeback_queue.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/reg_writeback_queue.sv
// Writeback queue for the register bank write port: buffers result writebacks,
// retires one per cycle onto C/Cdata/W, and forwards pending data to A/B reads.
module reg_writeback_queue #(
   parameter int DEPTH   = 4,
   parameter int AW      = 5,
   parameter int DW      = 64,
   parameter bit DROP_ZR = 1'b1
) (
   input  logic                       CLK,
   input  logic                       RST,
   input  logic                       inValid,
   output logic                       inReady,
   input  logic [AW-1:0]              inAddr,
   input  logic [DW-1:0]              inData,
   output logic [AW-1:0]              C,
   output logic [DW-1:0]              Cdata,
   output logic                       W,
   input  logic [AW-1:0]              A,
   input  logic [AW-1:0]              B,
   output logic [DW-1:0]              Afwd,
   output logic                       AfwdHit,
   output logic [DW-1:0]              Bfwd,
   output logic                       BfwdHit,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [AW-1:0] ZR_ADDR = AW'(31);
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   logic [AW-1:0] addr_mem_q [DEPTH];
   logic [DW-1:0] data_mem_q [DEPTH];

   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          w_q, w_d;
   logic [AW-1:0] c_q, c_d;
   logic [DW-1:0] cdata_q, cdata_d;

   logic          in_ready_s;
   logic          is_zr_s;
   logic          push_s;
   logic          pop_s;
   logic [DW:0]   a_lookup_s;
   logic [DW:0]   b_lookup_s;

   // Youngest match wins: issue register is oldest, then queue oldest->newest.
   function automatic logic [DW:0] fwd_lookup(
      input logic [AW-1:0] rd_addr,
      input logic          w_v,
      input logic [AW-1:0] c_v,
      input logic [DW-1:0] cdata_v,
      input logic [PW-1:0] rd_ptr_v,
      input logic [CW-1:0] count_v,
      input logic [AW-1:0] addrs [DEPTH],
      input logic [DW-1:0] datas [DEPTH]
   );
      logic          hit;
      logic [DW-1:0] data;
      logic [PW-1:0] idx;
      hit  = 1'b0;
      data = '0;
      if (w_v && (c_v == rd_addr)) begin
         hit  = 1'b1;
         data = cdata_v;
      end
      for (int i = 0; i < DEPTH; i++) begin
         idx = rd_ptr_v + PW'(i);
         if ((CW'(i) < count_v) && (addrs[idx] == rd_addr)) begin
            hit  = 1'b1;
            data = datas[idx];
         end
      end
      if (DROP_ZR && (rd_addr == ZR_ADDR)) begin
         hit  = 1'b0;
         data = '0;
      end
      return {hit, data};
   endfunction

   assign in_ready_s = !RST && (count_q < DEPTH_C);
   assign is_zr_s    = DROP_ZR && (inAddr == ZR_ADDR);
   // Zero-register writes still complete the handshake but are never stored.
   assign push_s     = inValid && in_ready_s && !is_zr_s;
   assign pop_s      = (count_q != '0);

   // Next-state for pointers, occupancy and the issue register.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      w_d      = 1'b0;
      c_d      = c_q;
      cdata_d  = cdata_q;
      if (pop_s) begin
         w_d      = 1'b1;
         c_d      = addr_mem_q[rd_ptr_q];
         cdata_d  = data_mem_q[rd_ptr_q];
         rd_ptr_d = rd_ptr_q + PW'(1);
      end else begin
         w_d      = 1'b0;
      end
      if (push_s) begin
         wr_ptr_d = wr_ptr_q + PW'(1);
      end else begin
         wr_ptr_d = wr_ptr_q;
      end
      case ({push_s, pop_s})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   // Control state and issue register, cleared by synchronous reset.
   always_ff @(posedge CLK) begin
      if (RST) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         w_q      <= 1'b0;
         c_q      <= '0;
         cdata_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         w_q      <= w_d;
         c_q      <= c_d;
         cdata_q  <= cdata_d;
      end
   end

   // Entry storage; validity is tracked only by the pointers and count.
   always_ff @(posedge CLK) begin
      if (push_s) begin
         addr_mem_q[wr_ptr_q] <= inAddr;
         data_mem_q[wr_ptr_q] <= inData;
      end
   end

   // Forwarding lookups for both decode read ports.
   always_comb begin
      a_lookup_s = fwd_lookup(A, w_q, c_q, cdata_q, rd_ptr_q, count_q, addr_mem_q, data_mem_q);
      b_lookup_s = fwd_lookup(B, w_q, c_q, cdata_q, rd_ptr_q, count_q, addr_mem_q, data_mem_q);
   end

   assign inReady = in_ready_s;
   assign C       = c_q;
   assign Cdata   = cdata_q;
   assign W       = w_q;
   assign count   = count_q;
   assign AfwdHit = a_lookup_s[DW];
   assign Afwd    = a_lookup_s[DW-1:0];
   assign BfwdHit = b_lookup_s[DW];
   assign Bfwd    = b_lookup_s[DW-1:0];

endmodule

// File: tb/tb_reg_writeback_queue.sv
// Bench for reg_writeback_queue: directed scenarios plus random traffic, all
// checked against a queue-based reference model of the writeback behaviour.
module tb_reg_writeback_queue;
   localparam int DEPTH = 4;
   localparam int AW    = 5;
   localparam int DW    = 64;

   logic          CLK = 1'b0;
   logic          RST;
   logic          inValid;
   logic          inReady;
   logic [AW-1:0] inAddr;
   logic [DW-1:0] inData;
   logic [AW-1:0] C;
   logic [DW-1:0] Cdata;
   logic          W;
   logic [AW-1:0] A;
   logic [AW-1:0] B;
   logic [DW-1:0] Afwd;
   logic          AfwdHit;
   logic [DW-1:0] Bfwd;
   logic          BfwdHit;
   logic [$clog2(DEPTH):0] count;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct packed {
      logic [AW-1:0] a;
      logic [DW-1:0] d;
   } wb_t;

   wb_t           mq[$];
   logic          m_w;
   logic [AW-1:0] m_c;
   logic [DW-1:0] m_cd;

   reg_writeback_queue #(.DEPTH(DEPTH), .AW(AW), .DW(DW), .DROP_ZR(1'b1)) dut (
      .CLK(CLK), .RST(RST), .inValid(inValid), .inReady(inReady),
      .inAddr(inAddr), .inData(inData), .C(C), .Cdata(Cdata), .W(W),
      .A(A), .B(B), .Afwd(Afwd), .AfwdHit(AfwdHit), .Bfwd(Bfwd),
      .BfwdHit(BfwdHit), .count(count)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference forwarding: newest queued entry first, then the issue register.
   function automatic logic [DW:0] m_fwd(input logic [AW-1:0] ad);
      if (ad == AW'(31)) return '0;
      for (int i = mq.size() - 1; i >= 0; i--)
         if (mq[i].a == ad) return {1'b1, mq[i].d};
      if (m_w && (m_c == ad)) return {1'b1, m_cd};
      return '0;
   endfunction

   // One cycle: drive at negedge, check all outputs, then advance the model.
   task automatic step(input logic rst, input logic v, input logic [AW-1:0] ia,
                       input logic [DW-1:0] id, input logic [AW-1:0] ra,
                       input logic [AW-1:0] rb);
      logic        exp_ready;
      logic [DW:0] fa;
      logic [DW:0] fb;
      wb_t         e;
      @(negedge CLK);
      RST = rst; inValid = v; inAddr = ia; inData = id; A = ra; B = rb;
      #1;
      exp_ready = !rst && (mq.size() < DEPTH);
      fa = m_fwd(ra);
      fb = m_fwd(rb);
      chk("inReady", DW'(inReady), DW'(exp_ready));
      chk("count",   DW'(count),   DW'(mq.size()));
      chk("W",       DW'(W),       DW'(m_w));
      chk("C",       DW'(C),       DW'(m_c));
      chk("Cdata",   Cdata,        m_cd);
      chk("AfwdHit", DW'(AfwdHit), DW'(fa[DW]));
      chk("Afwd",    Afwd,         fa[DW-1:0]);
      chk("BfwdHit", DW'(BfwdHit), DW'(fb[DW]));
      chk("Bfwd",    Bfwd,         fb[DW-1:0]);
      @(posedge CLK);
      if (rst) begin
         mq.delete();
         m_w = 1'b0; m_c = '0; m_cd = '0;
      end else begin
         if (mq.size() > 0) begin
            e = mq.pop_front();
            m_w = 1'b1; m_c = e.a; m_cd = e.d;
         end else begin
            m_w = 1'b0;
         end
         if (v && exp_ready && (ia != AW'(31))) mq.push_back(wb_t'({ia, id}));
      end
   endtask

   task automatic idle(input logic [AW-1:0] ra, input logic [AW-1:0] rb);
      step(1'b0, 1'b0, '0, '0, ra, rb);
   endtask

   initial begin
      logic [AW-1:0] ra;
      logic [DW-1:0] rd;
      int sel;
      RST = 1'b1; inValid = 1'b0; inAddr = '0; inData = '0; A = '0; B = '0;
      m_w = 1'b0; m_c = '0; m_cd = '0;
      repeat (2) @(posedge CLK);

      // Single write into empty queue
      step(1'b0, 1'b1, 5'd5, 64'hDEAD, 5'd5, 5'd0);
      #1 chk("t2_count1", DW'(count), 64'd1);
      idle(5'd5, 5'd0);
      #1 chk("t2_W1", DW'(W), 64'd1);
      chk("t2_C", DW'(C), 64'd5);
      chk("t2_Cdata", Cdata, 64'hDEAD);
      chk("t2_count0", DW'(count), 64'd0);
      idle(5'd5, 5'd0);
      #1 chk("t2_W0", DW'(W), 64'd0);
      idle(5'd5, 5'd0);

      // Forwarding priority on same address
      step(1'b0, 1'b1, 5'd7, 64'd1, 5'd7, 5'd3);
      step(1'b0, 1'b1, 5'd7, 64'd2, 5'd7, 5'd3);
      #1 chk("t4_hit", DW'(AfwdHit), 64'd1);
      chk("t4_fwd_q", Afwd, 64'd2);
      idle(5'd7, 5'd3);
      #1 chk("t4_fwd_issue", Afwd, 64'd2);
      idle(5'd7, 5'd3);
      #1 chk("t4_nohit", DW'(AfwdHit), 64'd0);

      // Zero register write is swallowed
      step(1'b0, 1'b1, 5'd31, 64'hFF, 5'd0, 5'd31);
      #1 chk("t5_count", DW'(count), 64'd0);
      idle(5'd0, 5'd31);
      #1 chk("t5_W", DW'(W), 64'd0);
      chk("t5_bhit", DW'(BfwdHit), 64'd0);

      // Back-to-back pushes while draining
      for (int i = 0; i < 5; i++)
         step(1'b0, 1'b1, AW'(i + 1), DW'(64'h100 + i), AW'(i + 1), 5'd2);
      idle(5'd3, 5'd5);

      // Reset held two cycles in the middle of traffic
      step(1'b0, 1'b1, 5'd9, 64'h99, 5'd9, 5'd4);
      step(1'b0, 1'b1, 5'd4, 64'h44, 5'd9, 5'd4);
      step(1'b1, 1'b1, 5'd6, 64'h66, 5'd9, 5'd4);
      step(1'b1, 1'b0, 5'd6, 64'h66, 5'd9, 5'd4);
      #1 chk("t1_W", DW'(W), 64'd0);
      chk("t1_count", DW'(count), 64'd0);
      chk("t1_C", DW'(C), 64'd0);
      chk("t1_Cdata", Cdata, 64'd0);
      chk("t1_hits", DW'({AfwdHit, BfwdHit}), 64'd0);
      idle(5'd9, 5'd4);

      // Random traffic including zero-register writes
      for (int i = 0; i < 60 * DEPTH; i++) begin
         sel = $urandom_range(0, 9);
         ra  = (sel > 7) ? 5'd31 : AW'(sel);
         rd  = {$urandom, $urandom};
         step(1'b0, 1'($urandom_range(0, 1)), ra, rd,
              AW'($urandom_range(0, 7)), (sel == 9) ? 5'd31 : AW'($urandom_range(0, 7)));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
